// File: rtl/alu_mc_ctrl.sv
// alu_mc_ctrl: ALU function-code decode plus an iterative shift-add multiplier driving HI/LO.
// Optional macro ALU_MUL_SIGNED_EN adds signed MULT (magnitude multiply, conditional final negate).
module alu_mc_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [1:0]       ALU_op,
    input  logic [5:0]       funct_ctrl,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [5:0]       funct,
    output logic [1:0]       result_sel,
    output logic             stall,
    output logic             mul_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    // state  | meaning
    // IDLE   | waiting for a multiply start
    // MUL    | one shift-add step per cycle, stall held high
    // DONE   | HI/LO just loaded, held instruction retires
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    localparam logic [5:0] FC_ADDU  = 6'b001011;
    localparam logic [5:0] FC_SUBU  = 6'b001101;
    localparam logic [5:0] FC_SLL   = 6'b100110;
    localparam logic [5:0] FC_SLLV  = 6'b110110;
    localparam logic [5:0] FC_MULTU = 6'b011001;
    localparam logic [5:0] FC_MFHI  = 6'b010000;
    localparam logic [5:0] FC_MFLO  = 6'b010010;

    logic [1:0]         state_q, state_d;
    logic [2*WIDTH:0]   p_q, p_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [CW-1:0]      count_q, count_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               mul_req;
    logic               start;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH:0]     upper_sum;
    logic [2*WIDTH:0]   p_step;
    logic [2*WIDTH-1:0] prod_raw;
    logic [2*WIDTH-1:0] prod_final;

    always_comb begin
        funct      = 6'b000000;
        result_sel = 2'b00;
        case (ALU_op)
            2'b00: funct = 6'b001001;
            2'b01: funct = 6'b001010;
            2'b11: funct = 6'b101010;
            default: begin
                case (funct_ctrl)
                    FC_ADDU: funct = 6'b001001;
                    FC_SUBU: funct = 6'b001010;
                    FC_SLL:  funct = 6'b100001;
                    FC_SLLV: funct = 6'b110101;
                    FC_MFHI: result_sel = 2'b01;
                    FC_MFLO: result_sel = 2'b10;
                    default: funct = 6'b000000;
                endcase
            end
        endcase
    end

`ifdef ALU_MUL_SIGNED_EN
    localparam logic [5:0] FC_MULT = 6'b011000;

    logic is_mult;
    logic neg_q;

    assign is_mult  = (ALU_op == 2'b10) && (funct_ctrl == FC_MULT);
    assign mul_req  = ((ALU_op == 2'b10) && (funct_ctrl == FC_MULTU)) || is_mult;
    assign op_a     = (is_mult && src_a[WIDTH-1]) ? -src_a : src_a;
    assign op_b     = (is_mult && src_b[WIDTH-1]) ? -src_b : src_b;
    assign prod_final = neg_q ? -prod_raw : prod_raw;

    // Sign of the product is fixed at the start edge, like the operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
        end else if (start) begin
            neg_q <= is_mult & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
        end
    end
`else
    assign mul_req    = (ALU_op == 2'b10) && (funct_ctrl == FC_MULTU);
    assign op_a       = src_a;
    assign op_b       = src_b;
    assign prod_final = prod_raw;
`endif

    // rst_n gates start so stall drops the moment reset asserts.
    assign start = rst_n & valid_in & (state_q == S_IDLE) & mul_req;

    assign upper_sum = p_q[0] ? ({1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q})
                              : p_q[2*WIDTH:WIDTH];
    assign p_step    = {1'b0, upper_sum, p_q[WIDTH-1:1]};
    assign prod_raw  = p_step[2*WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        mcand_d = mcand_q;
        count_d = count_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_MUL;
                    mcand_d = op_a;
                    p_d     = {{(WIDTH+1){1'b0}}, op_b};
                    count_d = '0;
                end
            end
            S_MUL: begin
                p_d     = p_step;
                count_d = count_q + CW'(1);
                if (count_q == LAST_CNT) begin
                    hi_d    = prod_final[2*WIDTH-1:WIDTH];
                    lo_d    = prod_final[WIDTH-1:0];
                    count_d = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            p_q     <= '0;
            mcand_q <= '0;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            mcand_q <= mcand_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign stall    = start | (state_q == S_MUL);
    assign mul_done = (state_q == S_DONE);
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_alu_mc_ctrl.sv
// Randomized scoreboard bench for alu_mc_ctrl: driver pushes expected HI:LO, monitor pops on mul_done.
module tb_alu_mc_ctrl;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         valid_in = 1'b0;
    logic [1:0]   ALU_op = 2'b00;
    logic [5:0]   funct_ctrl = 6'b000000;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic [5:0]   funct;
    logic [1:0]   result_sel;
    logic         stall;
    logic         mul_done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];
    logic [63:0] model_prod = '0;
    int stall_run = 0;
    int done_cnt = 0;

    alu_mc_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ALU_op(ALU_op),
        .funct_ctrl(funct_ctrl), .src_a(src_a), .src_b(src_b), .funct(funct),
        .result_sel(result_sel), .stall(stall), .mul_done(mul_done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Reference decode, written straight from the opcode table.
    function automatic logic [5:0] ref_funct(input logic [1:0] op, input logic [5:0] fc);
        if (op == 2'b00) return 6'b001001;
        if (op == 2'b01) return 6'b001010;
        if (op == 2'b11) return 6'b101010;
        if (fc == 6'b001011) return 6'b001001;
        if (fc == 6'b001101) return 6'b001010;
        if (fc == 6'b100110) return 6'b100001;
        if (fc == 6'b110110) return 6'b110101;
        return 6'b000000;
    endfunction

    function automatic logic [1:0] ref_sel(input logic [1:0] op, input logic [5:0] fc);
        if (op == 2'b10 && fc == 6'b010000) return 2'b01;
        if (op == 2'b10 && fc == 6'b010010) return 2'b10;
        return 2'b00;
    endfunction

    // Monitor: on each retiring multiply, compare HI:LO and the stall run length.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_run = 0;
        end else begin
            if (mul_done) begin
                done_cnt++;
                check("done_stall_low", {63'b0, stall}, 64'd0);
                check("stall_len", 64'(stall_run), 64'(W + 1));
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    check("product", {hi, lo}, exp_q.pop_front());
                end
            end
            if (stall) stall_run++;
            else stall_run = 0;
        end
    end

    task automatic issue(input logic [5:0] fc, input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk); #1;
        valid_in = 1'b1; ALU_op = 2'b10; funct_ctrl = fc; src_a = a; src_b = b;
    endtask

    task automatic wait_dones(input int n, input bit toggle);
        int seen = 0;
        int i = 0;
        while (seen < n && i < 100 * n) begin
            @(negedge clk);
            if (mul_done) seen++;
            else if (toggle && i >= 1) begin
                src_a = $urandom; src_b = $urandom;
            end
            i++;
        end
        check("mul_timeout", 64'(seen), 64'(n));
    endtask

    task automatic retire();
        @(posedge clk); #1;
        valid_in = 1'b0; src_a = $urandom; src_b = $urandom;
    endtask

    task automatic do_multu(input logic [W-1:0] a, input logic [W-1:0] b, input bit toggle);
        issue(6'b011001, a, b);
        model_prod = {32'b0, a} * {32'b0, b};
        exp_q.push_back(model_prod);
        wait_dones(1, toggle);
        retire();
    endtask

    task automatic read_hilo();
        @(posedge clk); #1;
        valid_in = 1'b1; ALU_op = 2'b10; funct_ctrl = 6'b010000;
        #1;
        check("mfhi_sel", {62'b0, result_sel}, 64'd1);
        check("mfhi_val", {32'b0, hi}, {32'b0, model_prod[63:32]});
        @(posedge clk); #1;
        funct_ctrl = 6'b010010;
        #1;
        check("mflo_sel", {62'b0, result_sel}, 64'd2);
        check("mflo_val", {32'b0, lo}, {32'b0, model_prod[31:0]});
        check("mfxx_stall", {63'b0, stall}, 64'd0);
        valid_in = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] ops [4];
        logic [5:0] fcs [5];
        ops = '{2'b00, 2'b01, 2'b11, 2'b10};
        fcs = '{6'b001011, 6'b001101, 6'b100110, 6'b110110, 6'b111111};

        #12;
        check("rst_hi", {32'b0, hi}, 64'd0);
        check("rst_lo", {32'b0, lo}, 64'd0);
        check("rst_stall", {63'b0, stall}, 64'd0);
        check("rst_done", {63'b0, mul_done}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Decode: directed table then random opcodes, valid_in low.
        for (int i = 0; i < 3; i++) begin
            ALU_op = ops[i]; funct_ctrl = 6'($urandom); #2;
            check("dec_op", {58'b0, funct}, {58'b0, ref_funct(ALU_op, funct_ctrl)});
        end
        for (int i = 0; i < 5; i++) begin
            ALU_op = 2'b10; funct_ctrl = fcs[i]; #2;
            check("dec_funct", {58'b0, funct}, {58'b0, ref_funct(ALU_op, funct_ctrl)});
        end
        for (int i = 0; i < 30; i++) begin
            ALU_op = 2'($urandom); funct_ctrl = 6'($urandom);
            if (i % 3 == 0) funct_ctrl = (i % 2 == 0) ? 6'b010000 : 6'b010010;
            #2;
            check("dec_rand_funct", {58'b0, funct}, {58'b0, ref_funct(ALU_op, funct_ctrl)});
            check("dec_rand_sel", {62'b0, result_sel}, {62'b0, ref_sel(ALU_op, funct_ctrl)});
            check("dec_no_stall", {63'b0, stall}, 64'd0);
        end

        do_multu(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("max_hi", {32'b0, hi}, 64'hFFFF_FFFE);
        check("max_lo", {32'b0, lo}, 64'h0000_0001);
        read_hilo();

        do_multu(32'h0001_2345, 32'h0, 1'b1);
        read_hilo();

        for (int i = 0; i < 8; i++) begin
            do_multu($urandom, $urandom, 1'($urandom));
            read_hilo();
        end

        // Reset in the middle of a multiply; the held instruction restarts.
        issue(6'b011001, 32'd7, 32'd9);
        exp_q.push_back(64'd63);
        repeat (10) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_stall", {63'b0, stall}, 64'd0);
        check("rst_mid_hilo", {hi, lo}, 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_prod = 64'd63;
        exp_q.push_back(model_prod);
        wait_dones(1, 1'b0);
        retire();
        read_hilo();

        // Held MULTU: second start follows the DONE cycle.
        issue(6'b011001, 32'h0000_1234, 32'h0000_5678);
        model_prod = 64'h0000_1234 * 64'h0000_5678;
        exp_q.push_back(model_prod);
        exp_q.push_back(model_prod);
        wait_dones(2, 1'b0);
        retire();

`ifdef ALU_MUL_SIGNED_EN
        issue(6'b011000, -32'sd3, 32'sd5);
        model_prod = 64'(longint'(-3) * longint'(5));
        exp_q.push_back(model_prod);
        wait_dones(1, 1'b0);
        retire();
        check("mult_hi", {32'b0, hi}, 64'hFFFF_FFFF);
        check("mult_lo", {32'b0, lo}, 64'hFFFF_FFF1);
        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = $urandom; b = $urandom;
            issue(6'b011000, a, b);
            model_prod = 64'(longint'($signed(a)) * longint'($signed(b)));
            exp_q.push_back(model_prod);
            wait_dones(1, 1'b1);
            retire();
        end
`else
        issue(6'b011000, -32'sd3, 32'sd5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("mult_no_stall", {63'b0, stall}, 64'd0);
            check("mult_no_done", {63'b0, mul_done}, 64'd0);
            check("mult_funct", {58'b0, funct}, 64'd0);
        end
        retire();
`endif

        repeat (3) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_mc_ctrl.md
# alu_mc_ctrl

Multi-cycle ALU control unit for the CPU datapath. It decodes `ALU_op`/`funct_ctrl` into the 6-bit ALU function code for single-cycle operations. It also runs an iterative shift-add multiplier for MULTU, writing HI/LO, and raises `stall` so the pipeline holds the issuing instruction. It sits between the main control and the ALU, alongside the register-file write-back mux.

## Interface
- `WIDTH`, 32, operand width in bits; legal range ≥ 2; HI and LO are each `WIDTH` bits.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `valid_in`  in  1  the instruction on `ALU_op`/`funct_ctrl`/operands is live this cycle.
- `ALU_op`  in  2  main-control ALU class.
- `funct_ctrl`  in  6  instruction funct field.
- `src_a`  in  `WIDTH`  multiplicand (rs).
- `src_b`  in  `WIDTH`  multiplier (rt).
- `funct`  out  6  ALU function code, combinational.
- `result_sel`  out  2  write-back source, combinational: 00 = ALU, 01 = HI, 10 = LO.
- `stall`  out  1  hold PC and pipeline registers.
- `mul_done`  out  1  one-cycle pulse; HI/LO were updated at the preceding edge.
- `hi`  out  `WIDTH`  HI register.
- `lo`  out  `WIDTH`  LO register.

## Operation
- `funct` decode:
  - `ALU_op` 00 → 001001.
  - `ALU_op` 01 → 001010.
  - `ALU_op` 11 → 101010.
  - `ALU_op` 10 uses `funct_ctrl`:
    - ADDU 001011 → 001001.
    - SUBU 001101 → 001010.
    - SLL 100110 → 100001.
    - SLLV 110110 → 110101.
    - All others, including MULTU 011001, MFHI 010000 and MFLO 010010 → 000000.
- `result_sel`: 01 when `ALU_op`=10 and `funct_ctrl`=MFHI; 10 for MFLO; otherwise 00. `valid_in` does not gate `funct`/`result_sel`.
- start = `valid_in` & state==IDLE & `ALU_op`==10 & `funct_ctrl`==MULTU.
- FSM states: IDLE, MUL, DONE.
  - IDLE → MUL on start. At that edge: capture `src_a` into the multiplicand register, load P = {(WIDTH+1)'b0, `src_b`}, clear count.
  - MUL, each cycle: if P[0], then P[2W:W] ← P[2W-1:W] + mcand, with a (W+1)-bit sum. Then P ← P >> 1 and count++.
  - When count == WIDTH-1: at the same edge, load `hi`/`lo` from the final shifted P[2W-1:0] and move to DONE.
  - DONE → IDLE unconditionally. A start condition in DONE is ignored; this is the held instruction retiring.
- `stall` = start | (state==MUL). `mul_done` = (state==DONE).
- Operands are sampled only at the start edge; later changes have no effect.
- Multiplication is unsigned. The product is exact over the full 2·WIDTH bits.

## Timing
- Reset (async, immediate): state = IDLE, `hi` = 0, `lo` = 0, `stall` = 0, `mul_done` = 0, P/count/mcand = 0.
- `stall` may still rise combinationally from start while `rst_n` is high.
- MULTU issue at cycle 0: `stall` is high in cycles 0..WIDTH (WIDTH+1 cycles).
  - `hi`/`lo` are valid from cycle WIDTH+1.
  - `mul_done` is high in cycle WIDTH+1 and `stall` is low there, so the instruction retires.
- Back-to-back MULTU: the next start is accepted no earlier than cycle WIDTH+2.
- Reset asserted mid-MUL: multiply is abandoned and HI/LO are cleared. After release, the FSM is in IDLE and a held MULTU restarts from scratch.
- MFHI/MFLO reads the registered `hi`/`lo`, which are stable outside the MUL→DONE edge.

## Configuration
- `ALU_MUL_SIGNED_EN` defined: `funct_ctrl` 011000 (MULT) with `ALU_op`=10 also starts a multiply.
  - Operands are converted to magnitudes at the start edge, and the sign flag (sign of a XOR sign of b) is latched.
  - At completion, the 2·WIDTH product is two's-complement negated before the HI/LO load when the flag is set.
  - Latency is identical to MULTU.
- Undefined: MULT decodes to `funct` 000000, never starts the FSM, and `stall` stays low.

## Test plan
- Decode sweep: each `ALU_op`, plus ADDU/SUBU/SLL/SLLV/illegal 111111 → `funct` 001001/001010/101010, then 001001/001010/100001/110101/000000.
- WIDTH=32, MULTU 0xFFFFFFFF×0xFFFFFFFF, held until retire:
  - `stall` high for exactly 33 cycles; `mul_done` in cycle 33.
  - `hi`=0xFFFFFFFE, `lo`=0x00000001.
  - MFHI then MFLO → `result_sel` 01 then 10.
- MULTU 0x00012345×0 with `src_a`/`src_b` toggled during MUL → `hi`=`lo`=0; the toggling has no effect.
- Reset pulse at cycle 10 of a MULTU 7×9:
  - `stall` drops immediately; `hi`/`lo` = 0.
  - After release the held MULTU reruns → `lo`=63 at cycle 33 after the restart.
- MULTU held continuously, `valid_in`=1 → second start at cycle 34, never in the DONE cycle 33.
- With `ALU_MUL_SIGNED_EN`: MULT −3×5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. Without it: no stall and `funct`=000000.
